alu_unit: RTL

- Single-cycle-latency integer execution unit directly downstream of the reservation station.
- Consumes one dispatched RV32I arithmetic, logic, branch or jump op per cycle (rs_to_alu_* bundle).
- Registers the result and broadcasts it as the common data bus (alu_to_rs_*) back to the reservation station and the ROB.
- Resolves control flow: produces the actual next PC and a taken flag for the ROB's mispredict check.

---
 rtl/alu_unit_pkg.sv | 32 +++
 rtl/alu_unit_if.sv | 35 +++
 rtl/alu_branch_cmp.sv | 24 ++
 rtl/alu_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/alu_unit_pkg.sv
// Shared types and op encoding for the integer execution unit.
// The op enum is shared verbatim with the decoder, RS and ROB.
package alu_unit_pkg;

  localparam int ROB_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 6;

  typedef logic [DATA_WIDTH-1:0] DATA_TYPE;
  typedef logic [31:0]           ADDR_TYPE;
  typedef logic [ROB_WIDTH-1:0]  ROB_INDEX_TYPE;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Codes 0 and 30..63 are undefined; the ALU still broadcasts them.
  typedef enum logic [OP_WIDTH-1:0] {
    LUI   = 6'd1,  AUIPC = 6'd2,  JAL   = 6'd3,  JALR  = 6'd4,
    BEQ   = 6'd5,  BNE   = 6'd6,  BLT   = 6'd7,  BGE   = 6'd8,
    BLTU  = 6'd9,  BGEU  = 6'd10, ADDI  = 6'd11, SLTI  = 6'd12,
    SLTIU = 6'd13, XORI  = 6'd14, ORI   = 6'd15, ANDI  = 6'd16,
    SLLI  = 6'd17, SRLI  = 6'd18, SRAI  = 6'd19, ADD   = 6'd20,
    SUB   = 6'd21, SLL   = 6'd22, SLT   = 6'd23, SLTU  = 6'd24,
    XOR   = 6'd25, SRL   = 6'd26, SRA   = 6'd27, OR    = 6'd28,
    AND   = 6'd29
  } OPENUM_TYPE;

  function automatic logic is_itype(input OPENUM_TYPE op);
    return (op >= ADDI) && (op <= SRAI);
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Dispatch bundle from the reservation station and CDB broadcast back.
interface alu_unit_if;
  import alu_unit_pkg::*;

  // rs_to_alu_ready is a dispatch valid with no backpressure: the ALU always
  // accepts. alu_to_rs_ready is the broadcast valid; consumers qualify it with rdy_in.
  logic                rs_to_alu_ready;
  logic [OP_WIDTH-1:0] rs_to_alu_op;
  DATA_TYPE            rs_to_alu_rs1;
  DATA_TYPE            rs_to_alu_rs2;
  DATA_TYPE            rs_to_alu_imm;
  ADDR_TYPE            rs_to_alu_PC;
  ROB_INDEX_TYPE       rs_to_alu_rob_index;

  logic                alu_to_rs_ready;
  DATA_TYPE            alu_to_rs_result;
  ROB_INDEX_TYPE       alu_to_rs_rob_index;
  logic                alu_jump;
  ADDR_TYPE            alu_next_PC;

  modport master (
    output rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
           rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index,
    input  alu_to_rs_ready, alu_to_rs_result, alu_to_rs_rob_index,
           alu_jump, alu_next_PC
  );

  modport slave (
    input  rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
           rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index,
    output alu_to_rs_ready, alu_to_rs_result, alu_to_rs_rob_index,
           alu_jump, alu_next_PC
  );

endinterface

// File: rtl/alu_branch_cmp.sv
// Combinational branch condition evaluator; non-branch ops report not taken.
module alu_branch_cmp
  import alu_unit_pkg::*;
(
  input  OPENUM_TYPE i_op,
  input  DATA_TYPE   i_rs1,
  input  DATA_TYPE   i_rs2,
  output logic       o_taken
);

  always_comb begin
    o_taken = FALSE;
    case (i_op)
      BEQ:     o_taken = (i_rs1 == i_rs2);
      BNE:     o_taken = (i_rs1 != i_rs2);
      BLT:     o_taken = ($signed(i_rs1) <  $signed(i_rs2));
      BGE:     o_taken = ($signed(i_rs1) >= $signed(i_rs2));
      BLTU:    o_taken = (i_rs1 <  i_rs2);
      BGEU:    o_taken = (i_rs1 >= i_rs2);
      default: o_taken = FALSE;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Single-cycle integer ALU: combinational datapath feeding a registered CDB
// broadcast, plus resolved next PC and taken flag for the ROB.
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       clr_in,
  alu_unit_if.slave  bus
);

  OPENUM_TYPE    w_op;
  DATA_TYPE      w_op2;
  logic [4:0]    w_shamt;
  ADDR_TYPE      w_pc4;
  logic          w_taken;
  DATA_TYPE      w_result;
  logic          w_jump;
  ADDR_TYPE      w_next_pc;

  logic          r_ready;
  DATA_TYPE      r_result;
  ROB_INDEX_TYPE r_rob_index;
  logic          r_jump;
  ADDR_TYPE      r_next_pc;

  assign w_op    = OPENUM_TYPE'(bus.rs_to_alu_op);
  assign w_op2   = is_itype(w_op) ? bus.rs_to_alu_imm : bus.rs_to_alu_rs2;
  assign w_shamt = w_op2[4:0];
  assign w_pc4   = bus.rs_to_alu_PC + 32'd4;

  alu_branch_cmp u_branch_cmp (
    .i_op    (w_op),
    .i_rs1   (bus.rs_to_alu_rs1),
    .i_rs2   (bus.rs_to_alu_rs2),
    .o_taken (w_taken)
  );

  always_comb begin
    w_result  = '0;
    w_jump    = FALSE;
    w_next_pc = w_pc4;
    case (w_op)
      ADD, ADDI:   w_result = bus.rs_to_alu_rs1 + w_op2;
      SUB:         w_result = bus.rs_to_alu_rs1 - w_op2;
      SLL, SLLI:   w_result = bus.rs_to_alu_rs1 << w_shamt;
      SRL, SRLI:   w_result = bus.rs_to_alu_rs1 >> w_shamt;
      SRA, SRAI:   w_result = DATA_TYPE'($signed(bus.rs_to_alu_rs1) >>> w_shamt);
      SLT, SLTI:   w_result = {31'b0, $signed(bus.rs_to_alu_rs1) < $signed(w_op2)};
      SLTU, SLTIU: w_result = {31'b0, bus.rs_to_alu_rs1 < w_op2};
      XOR, XORI:   w_result = bus.rs_to_alu_rs1 ^ w_op2;
      OR, ORI:     w_result = bus.rs_to_alu_rs1 | w_op2;
      AND, ANDI:   w_result = bus.rs_to_alu_rs1 & w_op2;
      LUI:         w_result = bus.rs_to_alu_imm;
      AUIPC:       w_result = bus.rs_to_alu_PC + bus.rs_to_alu_imm;
      JAL: begin
        w_result  = w_pc4;
        w_jump    = TRUE;
        w_next_pc = bus.rs_to_alu_PC + bus.rs_to_alu_imm;
      end
      JALR: begin
        w_result  = w_pc4;
        w_jump    = TRUE;
        w_next_pc = (bus.rs_to_alu_rs1 + bus.rs_to_alu_imm) & ~32'd1;
      end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
        w_result  = {31'b0, w_taken};
        w_jump    = w_taken;
        w_next_pc = w_taken ? (bus.rs_to_alu_PC + bus.rs_to_alu_imm) : w_pc4;
      end
      default: ;
    endcase
  end

  // Flush only kills the valid/jump flags; stale data behind a low valid is harmless.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ready     <= FALSE;
      r_result    <= '0;
      r_rob_index <= '0;
      r_jump      <= FALSE;
      r_next_pc   <= '0;
    end else if (clr_in) begin
      r_ready <= FALSE;
      r_jump  <= FALSE;
    end else if (rdy_in) begin
      r_ready <= bus.rs_to_alu_ready;
      if (bus.rs_to_alu_ready) begin
        r_result    <= w_result;
        r_rob_index <= bus.rs_to_alu_rob_index;
        r_jump      <= w_jump;
        r_next_pc   <= w_next_pc;
      end
    end
  end

  assign bus.alu_to_rs_ready     = r_ready;
  assign bus.alu_to_rs_result    = r_result;
  assign bus.alu_to_rs_rob_index = r_rob_index;
  assign bus.alu_jump            = r_jump;
  assign bus.alu_next_PC         = r_next_pc;

endmodule
